eu_operand_collector: RTL and testbench
=======================================

# eu_operand_collector

Parametrised operand-collection stage for the next-generation execution unit. Sits between the EU instruction queue and the ALU. It holds up to NUM_SLOTS dispatched instructions and captures their operands from NUM_RX_CHANNELS interconnect receive channels by tag match. It issues ready instructions oldest-first over a valid/ready port. This replaces the fixed two-channel, single-instruction-in-flight operand path with a multi-slot, multi-channel one.

## Interface
- NUM_RX_CHANNELS, 2: interconnect operand receive channels (≥1)
- NUM_SLOTS, 4: instruction slots (≥2)
- DATA_WIDTH, 32: operand width
- TAG_WIDTH, 8: operand/destination tag width
- OPCODE_WIDTH, 6: opcode width
- CNT_W, $clog2(NUM_SLOTS+1): occupancy width
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush_i  in  1  synchronous clear of all slots
- alloc_valid_i  in  1  dispatch request
- alloc_ready_o  out  1  a free slot exists
- alloc_opcode_i  in  OPCODE_WIDTH  opcode
- alloc_src_tag_i  in  2×TAG_WIDTH  operand tags, [0] and [1]
- alloc_src_rdy_i  in  2  operand already available
- alloc_src_data_i  in  2×DATA_WIDTH  data for available operands
- alloc_dst_tag_i  in  TAG_WIDTH  result tag
- rx_valid_i  in  NUM_RX_CHANNELS  per-channel operand valid
- rx_tag_i  in  NUM_RX_CHANNELS×TAG_WIDTH  per-channel tag
- rx_data_i  in  NUM_RX_CHANNELS×DATA_WIDTH  per-channel data
- rx_ready_o  out  NUM_RX_CHANNELS  per-channel accept
- issue_valid_o  out  1  instruction ready for ALU
- issue_ready_i  in  1  ALU accepts
- issue_opcode_o  out  OPCODE_WIDTH
- issue_op0_o, issue_op1_o  out  DATA_WIDTH each
- issue_dst_tag_o  out  TAG_WIDTH
- occupancy_o  out  CNT_W  valid slot count

## Operation
- Slot state: valid, opcode, dst tag, and per operand {tag, rdy, data}. An NUM_SLOTS×NUM_SLOTS age matrix records relative age.
- Alloc: the handshake completes when alloc_valid_i & alloc_ready_o. The lowest-index free slot is written, and its age row is set to "older-than-none". Every other valid slot is marked older than it.
- Operand capture applies only to slots valid at the start of the cycle. It compares each rx tag against every waiting operand (valid & !rdy).
- rx_ready_o[c] is combinational: rx_valid_i[c] & a match exists for c & no lower-index channel with rx_valid_i presents the same tag.
- On handshake, data is written to every matching waiting operand, and rdy is set.
- A channel with no match sees ready=0 and must hold its data. Unmatched operands are never dropped.
- Candidate slot: valid & both rdy at the start of the cycle. The selected slot is the candidate older than all other candidates. issue_* outputs are driven combinationally from the selected slot's registers.
- Once issue_valid_o rises, the selection is frozen until the handshake completes. A newly ready older slot does not preempt it.
- Issue handshake: issue_valid_o & issue_ready_i frees the slot at the clock edge.
- alloc_ready_o = any slot free at the start of the cycle. A slot freed by issue this cycle is not reusable until the next cycle.
- Flush: all slots invalid next cycle, and the frozen selection is cleared. Alloc, capture and issue handshakes in that cycle are ignored. rx_ready_o and alloc_ready_o are still computed normally, so senders must treat a flush cycle as a non-transfer.
- occupancy_o is registered: previous count + alloc − issue, or 0 on flush.

## Timing
- Reset values:
  - issue_valid_o=0; issue_op0_o, issue_op1_o, issue_opcode_o and issue_dst_tag_o=0.
  - rx_ready_o=0, occupancy_o=0, alloc_ready_o=1.
  - All slots invalid; age matrix 0.
- Reset mid-operation discards all slots, including a pending issue, immediately and asynchronously.
- Alloc with both operands rdy: issue_valid_o is asserted the next cycle (latency 1).
- Last operand captured in cycle N: issue_valid_o is asserted in cycle N+1. There is no same-cycle rx-to-issue bypass.
- Full (occupancy=NUM_SLOTS): alloc_ready_o=0. With issue_ready_i held high, throughput is one issue per cycle.
- The age matrix has no counters, so there is no wrap-around hazard.

## Test plan
- Reset, then alloc opcode 0x05 with tags {0x11,0x12}, rdy=2'b11, data {0x3,0x4}, dst 0x20 → issue_valid_o next cycle with op0=3, op1=4, dst=0x20; occupancy 1→0 after the handshake.
- Alloc slots A (tags 0x01/0x02) then B (tags 0x03/0x04), none rdy. Send 0x03,0x04 on ch0/ch1, then 0x01,0x02 → B issues first. With issue_ready_i low when A becomes ready, B stays selected; after B's handshake, A issues.
- Both channels present tag 0x07, which matches one waiting operand → rx_ready_o=2'b01, data from ch0 captured; ch1 is stalled until its tag matches a slot.
- Fill all 4 slots → alloc_ready_o=0. Issue handshake in cycle N → alloc_ready_o=1 in N+1, not N.
- rx tag 0x55 with no waiting match → rx_ready_o=0 for 10 cycles. Alloc a slot waiting on 0x55 → accepted the cycle after alloc, issue the following cycle.
- issue_valid_o high with 3 slots occupied, then assert flush_i → next cycle occupancy_o=0, issue_valid_o=0. Repeat using async reset mid-cycle → outputs reach reset values immediately.

Source files
------------

// File: rtl/eu_operand_collector.sv
// eu_operand_collector: multi-slot operand collection with tag-matched capture and oldest-first issue
module eu_operand_collector #(
  parameter int NUM_RX_CHANNELS = 2,
  parameter int NUM_SLOTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH = 8,
  parameter int OPCODE_WIDTH = 6,
  parameter int CNT_W = $clog2(NUM_SLOTS + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush_i,
  input  logic                                  alloc_valid_i,
  output logic                                  alloc_ready_o,
  input  logic [OPCODE_WIDTH-1:0]               alloc_opcode_i,
  input  logic [2*TAG_WIDTH-1:0]                alloc_src_tag_i,
  input  logic [1:0]                            alloc_src_rdy_i,
  input  logic [2*DATA_WIDTH-1:0]               alloc_src_data_i,
  input  logic [TAG_WIDTH-1:0]                  alloc_dst_tag_i,
  input  logic [NUM_RX_CHANNELS-1:0]            rx_valid_i,
  input  logic [NUM_RX_CHANNELS*TAG_WIDTH-1:0]  rx_tag_i,
  input  logic [NUM_RX_CHANNELS*DATA_WIDTH-1:0] rx_data_i,
  output logic [NUM_RX_CHANNELS-1:0]            rx_ready_o,
  output logic                                  issue_valid_o,
  input  logic                                  issue_ready_i,
  output logic [OPCODE_WIDTH-1:0]               issue_opcode_o,
  output logic [DATA_WIDTH-1:0]                 issue_op0_o,
  output logic [DATA_WIDTH-1:0]                 issue_op1_o,
  output logic [TAG_WIDTH-1:0]                  issue_dst_tag_o,
  output logic [CNT_W-1:0]                      occupancy_o
);
  localparam int SW = $clog2(NUM_SLOTS);
  logic [NUM_SLOTS-1:0]       valid_q, valid_d, cand, oldest;
  logic [OPCODE_WIDTH-1:0]    opcode_q [NUM_SLOTS], opcode_d [NUM_SLOTS];
  logic [TAG_WIDTH-1:0]       dst_q [NUM_SLOTS], dst_d [NUM_SLOTS];
  logic [TAG_WIDTH-1:0]       tag_q [NUM_SLOTS][2], tag_d [NUM_SLOTS][2];
  logic [1:0]                 rdy_q [NUM_SLOTS], rdy_d [NUM_SLOTS];
  logic [DATA_WIDTH-1:0]      data_q [NUM_SLOTS][2], data_d [NUM_SLOTS][2];
  logic [NUM_SLOTS-1:0]       age_q [NUM_SLOTS], age_d [NUM_SLOTS];
  logic                       lock_q, lock_d;
  logic [SW-1:0]              lock_idx_q, lock_idx_d, sel, oldest_idx, free_idx;
  logic [CNT_W-1:0]           occ_q, occ_d;
  logic [NUM_RX_CHANNELS-1:0] rx_match, rx_dup, rx_fire;
  logic                       alloc_fire, issue_fire;

  // A channel repeating a tag already offered by a lower channel waits its turn
  always_comb begin
    rx_match = '0;
    rx_dup = '0;
    for (int c = 0; c < NUM_RX_CHANNELS; c++) begin
      for (int s = 0; s < NUM_SLOTS; s++)
        for (int k = 0; k < 2; k++)
          if (valid_q[s] && !rdy_q[s][k] && tag_q[s][k] == rx_tag_i[c*TAG_WIDTH +: TAG_WIDTH]) rx_match[c] = 1'b1;
      for (int p = 0; p < c; p++)
        if (rx_valid_i[p] && rx_tag_i[p*TAG_WIDTH +: TAG_WIDTH] == rx_tag_i[c*TAG_WIDTH +: TAG_WIDTH]) rx_dup[c] = 1'b1;
    end
    rx_ready_o = rx_valid_i & rx_match & ~rx_dup;
    rx_fire = rx_ready_o & {NUM_RX_CHANNELS{~flush_i}};
  end

  // age_q[i][j] set means slot i is older than slot j
  always_comb begin
    cand = '0;
    oldest = '0;
    oldest_idx = '0;
    free_idx = '0;
    for (int s = 0; s < NUM_SLOTS; s++) cand[s] = valid_q[s] & (&rdy_q[s]);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      oldest[i] = cand[i];
      for (int j = 0; j < NUM_SLOTS; j++)
        if (j != i && cand[j] && !age_q[i][j]) oldest[i] = 1'b0;
    end
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (oldest[s]) oldest_idx = SW'(s);
      if (!valid_q[s]) free_idx = SW'(s);
    end
    sel = lock_q ? lock_idx_q : oldest_idx;
    issue_valid_o = lock_q | (|cand);
    issue_opcode_o = issue_valid_o ? opcode_q[sel] : '0;
    issue_op0_o = issue_valid_o ? data_q[sel][0] : '0;
    issue_op1_o = issue_valid_o ? data_q[sel][1] : '0;
    issue_dst_tag_o = issue_valid_o ? dst_q[sel] : '0;
    alloc_ready_o = ~&valid_q;
    occupancy_o = occ_q;
  end

  always_comb begin
    valid_d = valid_q;
    opcode_d = opcode_q;
    dst_d = dst_q;
    tag_d = tag_q;
    rdy_d = rdy_q;
    data_d = data_q;
    age_d = age_q;
    alloc_fire = alloc_valid_i & alloc_ready_o & ~flush_i;
    issue_fire = issue_valid_o & issue_ready_i & ~flush_i;
    for (int s = 0; s < NUM_SLOTS; s++)
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < NUM_RX_CHANNELS; c++)
          if (rx_fire[c] && valid_q[s] && !rdy_q[s][k] && tag_q[s][k] == rx_tag_i[c*TAG_WIDTH +: TAG_WIDTH]) begin
            rdy_d[s][k] = 1'b1;
            data_d[s][k] = rx_data_i[c*DATA_WIDTH +: DATA_WIDTH];
          end
    if (issue_fire) valid_d[sel] = 1'b0;
    if (alloc_fire) begin
      valid_d[free_idx] = 1'b1;
      opcode_d[free_idx] = alloc_opcode_i;
      dst_d[free_idx] = alloc_dst_tag_i;
      rdy_d[free_idx] = alloc_src_rdy_i;
      for (int k = 0; k < 2; k++) begin
        tag_d[free_idx][k] = alloc_src_tag_i[k*TAG_WIDTH +: TAG_WIDTH];
        data_d[free_idx][k] = alloc_src_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
      age_d[free_idx] = '0;
      for (int s = 0; s < NUM_SLOTS; s++) age_d[s][free_idx] = valid_q[s];
    end
    if (flush_i) valid_d = '0;
    lock_d = issue_valid_o & ~issue_ready_i & ~flush_i;
    lock_idx_d = sel;
    occ_d = flush_i ? '0 : occ_q + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_q <= '0;
      opcode_q <= '{default: '0};
      dst_q <= '{default: '0};
      tag_q <= '{default: '0};
      rdy_q <= '{default: '0};
      data_q <= '{default: '0};
      age_q <= '{default: '0};
      lock_q <= 1'b0;
      lock_idx_q <= '0;
      occ_q <= '0;
    end else begin
      valid_q <= valid_d;
      opcode_q <= opcode_d;
      dst_q <= dst_d;
      tag_q <= tag_d;
      rdy_q <= rdy_d;
      data_q <= data_d;
      age_q <= age_d;
      lock_q <= lock_d;
      lock_idx_q <= lock_idx_d;
      occ_q <= occ_d;
    end
endmodule

// File: tb/tb_eu_operand_collector.sv
// tb_eu_operand_collector: directed vector table plus hand sequences for ordering, stall, full, flush and reset
module tb_eu_operand_collector;
  logic        clk = 1'b0, reset = 1'b1, flush_i = 1'b0, alloc_valid_i = 1'b0, issue_ready_i = 1'b0;
  logic        alloc_ready_o, issue_valid_o;
  logic [5:0]  alloc_opcode_i = '0, issue_opcode_o;
  logic [15:0] alloc_src_tag_i = '0, rx_tag_i = '0;
  logic [1:0]  alloc_src_rdy_i = '0, rx_valid_i = '0, rx_ready_o;
  logic [63:0] alloc_src_data_i = '0, rx_data_i = '0;
  logic [7:0]  alloc_dst_tag_i = '0, issue_dst_tag_o;
  logic [31:0] issue_op0_o, issue_op1_o;
  logic [2:0]  occupancy_o;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic av; logic [5:0] op; logic [15:0] stag; logic [1:0] srdy; logic [63:0] sdata; logic [7:0] dst;
    logic [1:0] rv; logic [15:0] rtag; logic [63:0] rdata; logic ir;
    logic e_iv; logic [5:0] e_opc; logic [31:0] e_op0; logic [31:0] e_op1; logic [7:0] e_dst;
    logic e_ar; logic [1:0] e_rr; logic [2:0] e_occ;
  } vec_t;
  vec_t tv [16];

  eu_operand_collector dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_opcode_i(alloc_opcode_i),
    .alloc_src_tag_i(alloc_src_tag_i), .alloc_src_rdy_i(alloc_src_rdy_i), .alloc_src_data_i(alloc_src_data_i),
    .alloc_dst_tag_i(alloc_dst_tag_i), .rx_valid_i(rx_valid_i), .rx_tag_i(rx_tag_i), .rx_data_i(rx_data_i),
    .rx_ready_o(rx_ready_o), .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_opcode_o(issue_opcode_o), .issue_op0_o(issue_op0_o), .issue_op1_o(issue_op1_o),
    .issue_dst_tag_o(issue_dst_tag_o), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid_i = 1'b0; alloc_opcode_i = '0; alloc_src_tag_i = '0; alloc_src_rdy_i = '0;
    alloc_src_data_i = '0; alloc_dst_tag_i = '0; rx_valid_i = '0; rx_tag_i = '0; rx_data_i = '0;
    issue_ready_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic alloc(input logic [5:0] op, input logic [15:0] st, input logic [1:0] sr,
                       input logic [63:0] sd, input logic [7:0] dt);
    alloc_valid_i = 1'b1; alloc_opcode_i = op; alloc_src_tag_i = st;
    alloc_src_rdy_i = sr; alloc_src_data_i = sd; alloc_dst_tag_i = dt;
  endtask

  task automatic drive(input vec_t v);
    alloc_valid_i = v.av; alloc_opcode_i = v.op; alloc_src_tag_i = v.stag; alloc_src_rdy_i = v.srdy;
    alloc_src_data_i = v.sdata; alloc_dst_tag_i = v.dst; rx_valid_i = v.rv; rx_tag_i = v.rtag;
    rx_data_i = v.rdata; issue_ready_i = v.ir;
  endtask

  initial begin
    // fully-ready alloc issues next cycle
    tv[0]  = '{1'b1, 6'h05, 16'h1211, 2'b11, {32'h4, 32'h3}, 8'h20, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, 1'b1, '0, 3'd0};
    tv[1]  = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b1,
               1'b1, 6'h05, 32'h3, 32'h4, 8'h20, 1'b1, '0, 3'd1};
    tv[2]  = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, 1'b1, '0, 3'd0};
    // A then B, B's operands arrive first and B keeps the frozen selection
    tv[3]  = '{1'b1, 6'h01, 16'h0201, 2'b00, '0, 8'h30, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, 1'b1, '0, 3'd0};
    tv[4]  = '{1'b1, 6'h02, 16'h0403, 2'b00, '0, 8'h31, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, 1'b1, '0, 3'd1};
    tv[5]  = '{'0, '0, '0, '0, '0, '0, 2'b11, 16'h0403, {32'hB1, 32'hB0}, '0,
               '0, '0, '0, '0, '0, 1'b1, 2'b11, 3'd2};
    tv[6]  = '{'0, '0, '0, '0, '0, '0, 2'b11, 16'h0201, {32'hA1, 32'hA0}, '0,
               1'b1, 6'h02, 32'hB0, 32'hB1, 8'h31, 1'b1, 2'b11, 3'd2};
    tv[7]  = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0,
               1'b1, 6'h02, 32'hB0, 32'hB1, 8'h31, 1'b1, '0, 3'd2};
    tv[8]  = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b1,
               1'b1, 6'h02, 32'hB0, 32'hB1, 8'h31, 1'b1, '0, 3'd2};
    tv[9]  = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b1,
               1'b1, 6'h01, 32'hA0, 32'hA1, 8'h30, 1'b1, '0, 3'd1};
    tv[10] = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, 1'b1, '0, 3'd0};
    // both channels offer 0x07: only ch0 accepted, ch1 stalls
    tv[11] = '{1'b1, 6'h03, 16'h0807, 2'b00, '0, 8'h40, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, 1'b1, '0, 3'd0};
    tv[12] = '{'0, '0, '0, '0, '0, '0, 2'b11, 16'h0707, {32'hC1, 32'hC0}, '0,
               '0, '0, '0, '0, '0, 1'b1, 2'b01, 3'd1};
    tv[13] = '{'0, '0, '0, '0, '0, '0, 2'b11, 16'h0708, {32'hC1, 32'hC8}, '0,
               '0, '0, '0, '0, '0, 1'b1, 2'b01, 3'd1};
    tv[14] = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b1,
               1'b1, 6'h03, 32'hC0, 32'hC8, 8'h40, 1'b1, '0, 3'd1};
    tv[15] = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0,
               '0, '0, '0, '0, '0, 1'b1, '0, 3'd0};

    rx_valid_i = 2'b11; rx_tag_i = 16'h0101;
    #12;
    chk("reset issue_valid", issue_valid_o, 1'b0);
    chk("reset alloc_ready", alloc_ready_o, 1'b1);
    chk("reset rx_ready", rx_ready_o, 2'b00);
    chk("reset occupancy", occupancy_o, 3'd0);
    chk("reset op0", issue_op0_o, 32'h0);
    idle();
    @(negedge clk);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d issue_valid", i), issue_valid_o, tv[i].e_iv);
      chk($sformatf("v%0d opcode", i), issue_opcode_o, tv[i].e_opc);
      chk($sformatf("v%0d op0", i), issue_op0_o, tv[i].e_op0);
      chk($sformatf("v%0d op1", i), issue_op1_o, tv[i].e_op1);
      chk($sformatf("v%0d dst", i), issue_dst_tag_o, tv[i].e_dst);
      chk($sformatf("v%0d alloc_ready", i), alloc_ready_o, tv[i].e_ar);
      chk($sformatf("v%0d rx_ready", i), rx_ready_o, tv[i].e_rr);
      chk($sformatf("v%0d occupancy", i), occupancy_o, tv[i].e_occ);
      tick();
    end

    // unmatched tag held for 10 cycles, then a slot waiting on it arrives
    idle();
    rx_valid_i = 2'b01; rx_tag_i = 16'h0055; rx_data_i = {32'h0, 32'h55AA};
    for (int i = 0; i < 10; i++) begin
      #1 chk("stall rx_ready", rx_ready_o, 2'b00);
      tick();
    end
    alloc(6'h07, 16'h6655, 2'b10, {32'h66, 32'h0}, 8'h60);
    #1 chk("late alloc-cycle rx_ready", rx_ready_o, 2'b00);
    tick();
    alloc_valid_i = 1'b0; issue_ready_i = 1'b1;
    #1 chk("late accept rx_ready", rx_ready_o, 2'b01);
    chk("late no bypass issue_valid", issue_valid_o, 1'b0);
    tick();
    rx_valid_i = '0;
    #1 chk("late issue_valid", issue_valid_o, 1'b1);
    chk("late op0", issue_op0_o, 32'h55AA);
    chk("late op1", issue_op1_o, 32'h66);
    chk("late dst", issue_dst_tag_o, 8'h60);
    chk("late opcode", issue_opcode_o, 6'h07);
    tick();
    issue_ready_i = 1'b0;
    #1 chk("late drained occupancy", occupancy_o, 3'd0);

    // fill all slots, then drain one per cycle oldest-first
    for (int i = 0; i < 4; i++) begin
      alloc(6'(i + 8), 16'hEEEE, 2'b11, {32'(i + 'h100), 32'(i)}, 8'(8'h50 + i));
      #1 chk("fill alloc_ready", alloc_ready_o, 1'b1);
      tick();
    end
    issue_ready_i = 1'b1;
    #1 chk("full alloc_ready", alloc_ready_o, 1'b0);
    chk("full occupancy", occupancy_o, 3'd4);
    chk("full dst", issue_dst_tag_o, 8'h50);
    tick();
    alloc_valid_i = 1'b0;
    #1 chk("freed alloc_ready", alloc_ready_o, 1'b1);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("drain%0d issue_valid", i), issue_valid_o, 1'b1);
      chk($sformatf("drain%0d dst", i), issue_dst_tag_o, 8'(8'h50 + i));
      chk($sformatf("drain%0d op1", i), issue_op1_o, 32'(i + 'h100));
      chk($sformatf("drain%0d occupancy", i), occupancy_o, 3'(4 - i));
      tick();
    end
    issue_ready_i = 1'b0;
    #1 chk("drained issue_valid", issue_valid_o, 1'b0);
    chk("drained occupancy", occupancy_o, 3'd0);

    // flush with a pending issue
    for (int i = 0; i < 3; i++) begin
      alloc(6'h0A, 16'h0000, 2'b11, {32'h1, 32'(i)}, 8'(8'h70 + i));
      tick();
    end
    alloc_valid_i = 1'b0;
    #1 chk("preflush issue_valid", issue_valid_o, 1'b1);
    chk("preflush occupancy", occupancy_o, 3'd3);
    chk("preflush dst", issue_dst_tag_o, 8'h70);
    tick();
    flush_i = 1'b1; issue_ready_i = 1'b1;
    alloc(6'h0B, 16'h0000, 2'b11, 64'h0, 8'h7F);
    #1 chk("flush-cycle alloc_ready", alloc_ready_o, 1'b1);
    tick();
    idle();
    #1 chk("postflush occupancy", occupancy_o, 3'd0);
    chk("postflush issue_valid", issue_valid_o, 1'b0);
    chk("postflush alloc_ready", alloc_ready_o, 1'b1);
    tick();

    // asynchronous reset with a pending issue
    for (int i = 0; i < 3; i++) begin
      alloc(6'h0C, 16'h0000, 2'b11, {32'h2, 32'h9}, 8'(8'h78 + i));
      tick();
    end
    alloc_valid_i = 1'b0;
    #1 chk("prereset issue_valid", issue_valid_o, 1'b1);
    #2 reset = 1'b1;
    #1 chk("async reset issue_valid", issue_valid_o, 1'b0);
    chk("async reset occupancy", occupancy_o, 3'd0);
    chk("async reset opcode", issue_opcode_o, 6'h0);
    chk("async reset op0", issue_op0_o, 32'h0);
    chk("async reset dst", issue_dst_tag_o, 8'h0);
    chk("async reset alloc_ready", alloc_ready_o, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
